// File: rtl/rob_if.sv
// Reorder buffer bus bundle: issue, CDB writeback, operand query, commit.
// master drives issue/writeback/query requests; slave is the buffer itself.
interface rob_if #(
    parameter int POS_W = 4
);
    logic             issue;
    logic [4:0]       issue_rd;
    logic [31:0]      issue_pc;
    logic             issue_is_br;
    logic             issue_pred;
    logic [POS_W-1:0] issue_rob_pos;
    logic             full;

    logic             wb_valid;
    logic [POS_W-1:0] wb_rob_pos;
    logic [31:0]      wb_val;
    logic             wb_jump;
    logic [31:0]      wb_target;

    logic [POS_W-1:0] qry1_pos;
    logic [POS_W-1:0] qry2_pos;
    logic             qry1_ready;
    logic             qry2_ready;
    logic [31:0]      qry1_val;
    logic [31:0]      qry2_val;

    logic             commit;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_val;
    logic [POS_W-1:0] commit_rob_pos;
    logic             rollback;
    logic [31:0]      rollback_pc;

    modport master (
        output issue, issue_rd, issue_pc, issue_is_br, issue_pred,
        output wb_valid, wb_rob_pos, wb_val, wb_jump, wb_target,
        output qry1_pos, qry2_pos,
        input  issue_rob_pos, full, qry1_ready, qry2_ready,
        input  qry1_val, qry2_val,
        input  commit, commit_rd, commit_val, commit_rob_pos,
        input  rollback, rollback_pc
    );

    modport slave (
        input  issue, issue_rd, issue_pc, issue_is_br, issue_pred,
        input  wb_valid, wb_rob_pos, wb_val, wb_jump, wb_target,
        input  qry1_pos, qry2_pos,
        output issue_rob_pos, full, qry1_ready, qry2_ready,
        output qry1_val, qry2_val,
        output commit, commit_rd, commit_val, commit_rob_pos,
        output rollback, rollback_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer with CDB capture and operand queries.
// Optional: define ROB_CDB_FORWARD_EN to forward a same-cycle CDB result to queries.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int POS_W    = 4
) (
    input logic  clk,
    input logic  rst,
    input logic  rdy,
    rob_if.slave rob
);
    localparam int CNT_W = POS_W + 1;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pc;
        logic        is_br;
        logic        pred;
        logic        jump;
        logic [31:0] target;
    } entry_t;

    entry_t           entry_q [ROB_SIZE];
    entry_t           entry_d [ROB_SIZE];
    logic [POS_W-1:0] head_q, head_d;
    logic [POS_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    entry_t hd;
    logic   full;
    logic   commit;
    logic   rollback;
    logic   issue_acc;
    logic   wb_acc;
    logic   fwd1, fwd2;

    assign hd        = entry_q[head_q];
    assign full      = (count_q == CNT_W'(ROB_SIZE));
    assign commit    = rdy && hd.valid && hd.ready;
    assign rollback  = commit && hd.is_br && (hd.jump != hd.pred);
    assign issue_acc = rdy && rob.issue && !full && !rollback;
    assign wb_acc    = rdy && rob.wb_valid && entry_q[rob.wb_rob_pos].valid;

`ifdef ROB_CDB_FORWARD_EN
    assign fwd1 = wb_acc && (rob.wb_rob_pos == rob.qry1_pos);
    assign fwd2 = wb_acc && (rob.wb_rob_pos == rob.qry2_pos);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign rob.issue_rob_pos  = tail_q;
    assign rob.full           = full;
    assign rob.commit         = commit;
    assign rob.commit_rd      = (commit && !hd.is_br) ? hd.rd : 5'd0;
    assign rob.commit_val     = commit ? hd.val : 32'd0;
    assign rob.commit_rob_pos = commit ? head_q : '0;
    assign rob.rollback       = rollback;
    assign rob.rollback_pc    = !rollback ? 32'd0 :
                                hd.jump ? hd.target : hd.pc + 32'd4;

    // Operand lookup for renamed sources, optionally bypassing the CDB.
    always_comb begin
        rob.qry1_ready = entry_q[rob.qry1_pos].valid && entry_q[rob.qry1_pos].ready;
        rob.qry1_val   = rob.qry1_ready ? entry_q[rob.qry1_pos].val : 32'd0;
        rob.qry2_ready = entry_q[rob.qry2_pos].valid && entry_q[rob.qry2_pos].ready;
        rob.qry2_val   = rob.qry2_ready ? entry_q[rob.qry2_pos].val : 32'd0;
        if (fwd1) begin
            rob.qry1_ready = 1'b1;
            rob.qry1_val   = rob.wb_val;
        end
        if (fwd2) begin
            rob.qry2_ready = 1'b1;
            rob.qry2_val   = rob.wb_val;
        end
    end

    // Next state: a mispredict flush wins over writeback, retire and allocate.
    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rollback) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entry_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_acc) begin
                entry_d[rob.wb_rob_pos].ready  = 1'b1;
                entry_d[rob.wb_rob_pos].val    = rob.wb_val;
                entry_d[rob.wb_rob_pos].jump   = rob.wb_jump;
                entry_d[rob.wb_rob_pos].target = rob.wb_target;
            end
            if (commit) begin
                entry_d[head_q].valid = 1'b0;
                entry_d[head_q].ready = 1'b0;
                head_d = head_q + POS_W'(1);
            end
            if (issue_acc) begin
                entry_d[tail_q].valid  = 1'b1;
                entry_d[tail_q].ready  = 1'b0;
                entry_d[tail_q].rd     = rob.issue_rd;
                entry_d[tail_q].val    = 32'd0;
                entry_d[tail_q].pc     = rob.issue_pc;
                entry_d[tail_q].is_br  = rob.issue_is_br;
                entry_d[tail_q].pred   = rob.issue_pred;
                entry_d[tail_q].jump   = 1'b0;
                entry_d[tail_q].target = 32'd0;
                tail_d = tail_q + POS_W'(1);
            end
            count_d = count_q + CNT_W'(issue_acc) - CNT_W'(commit);
        end
    end

    // State registers; reset empties the buffer regardless of rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

16-entry circular reorder buffer between the decoder/issue stage and the register file. It allocates a slot per issued instruction and captures results from the common data bus (CDB). It retires instructions in program order, driving the register file's commit port, and raises `rollback` on a branch mispredict. It also answers operand queries for renamed registers so the decoder can pick up completed but uncommitted values.

## Interface
Parameters:
- `ROB_SIZE`, 16: entry count; must be a power of two.
- `POS_W`, 4: log2(`ROB_SIZE`); width of slot positions.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, all state holds and `commit`/`rollback` are 0.
- `issue` in 1: allocate the tail slot this cycle.
- `issue_rd` in 5: destination register (0 means no writeback).
- `issue_pc` in 32: instruction PC.
- `issue_is_br` in 1: conditional branch.
- `issue_pred` in 1: predicted taken.
- `issue_rob_pos` out `POS_W`: current tail, i.e. the slot the next `issue` takes.
- `full` out 1: all 16 slots valid.
- `wb_valid` in 1: CDB result valid.
- `wb_rob_pos` in `POS_W`: target slot.
- `wb_val` in 32: result value.
- `wb_jump` in 1: actual branch outcome.
- `wb_target` in 32: taken-branch target.
- `qry1_pos`, `qry2_pos` in `POS_W`: slots being queried.
- `qry1_ready`, `qry2_ready` out 1: queried slot holds a result.
- `qry1_val`, `qry2_val` out 32: queried slot's value.
- `commit` out 1: head retires this cycle.
- `commit_rd` out 5, `commit_val` out 32, `commit_rob_pos` out `POS_W`: retiring entry's fields.
- `rollback` out 1: flush on mispredict.
- `rollback_pc` out 32: redirect PC.

## Operation
- Each entry holds: valid, ready, rd, val, pc, is_br, pred, jump, target.
- Pointers `head` and `tail` are `POS_W` bits and wrap naturally 15→0. `count` is `POS_W`+1 bits.
- Issue (when `rdy && issue && !full && !rollback`):
  - Write the entry at `tail`: valid=1, ready=0, plus rd, pc, is_br, pred.
  - Advance `tail`.
  - Issue while `full` is a protocol violation and is ignored.
- Writeback (when `rdy && wb_valid`) on a valid slot: set ready=1 and store val, jump, target. Writeback to an invalid slot is ignored.
- Commit (combinational) is `rdy && entry[head].valid && entry[head].ready`.
  - `commit_rd` = head's rd; `commit_val` = head's val; `commit_rob_pos` = `head`.
  - For branches, `commit_rd` = 0.
  - At the clock edge, clear the head entry and advance `head`.
- Rollback (combinational) is `commit && is_br && (jump != pred)`.
  - `rollback_pc` = target if jump is set, else pc+4. It is 0 when there is no rollback.
  - At the clock edge, clear every valid bit and set head=tail=count=0.
  - A concurrent issue or writeback in that cycle is dropped.
- Count update: count += issue_accepted − commit. Simultaneous issue and commit leaves count unchanged.
- Query: `qryN_ready` = valid && ready for the queried slot; `qryN_val` = that slot's val (0 if not ready).

## Timing
- Reset: all entries invalid, head=tail=count=0, and every output is 0 (`issue_rob_pos`=0, `full`=0).
- Issue at edge E; a writeback is accepted from the cycle after E.
- Writeback at edge N; the entry can commit in cycle N+1 (`commit` is high combinationally during that cycle). Minimum issue-to-commit is 2 cycles.
- At most one commit per cycle.
- `full` is combinational from registered `count` (=16). It deasserts in the cycle after a commit frees a slot.
- A full buffer that commits and issues in the same cycle is not allowed: the issue is ignored because `full` is sampled pre-edge.
- `rst` mid-operation discards all entries at the next edge, regardless of `rdy`.

## Configuration
- `ROB_CDB_FORWARD_EN` defined: a query that matches `wb_rob_pos` while `wb_valid` is high returns ready=1 and val=`wb_val` in the same cycle.
- `ROB_CDB_FORWARD_EN` undefined: a query sees the value only from the cycle after the writeback edge.

## Test plan
- Reset, issue rd=5 (slot 0), writeback slot 0 with val 0x1234 → next cycle `commit`=1, `commit_rd`=5, `commit_val`=0x1234, `commit_rob_pos`=0; then head=1.
- Issue 16 instructions with no writebacks → `full`=1 and `issue_rob_pos`=0 (wrapped). A 17th issue is ignored. Writeback and commit slot 0 → `full`=0 the following cycle.
- Writeback slots 2, 1, 0 out of order → commits occur in order 0, 1, 2 on consecutive cycles.
- Branch at pc 0x100, pred=0, wb_jump=1, target 0x200, followed by 3 younger entries → `rollback`=1, `rollback_pc`=0x200 when it commits. Afterwards `count`=0 and `issue_rob_pos`=0, and the younger entries never commit.
- Query slot 3 in the same cycle as the slot-3 writeback of 0xABCD → ready=1/val=0xABCD with `ROB_CDB_FORWARD_EN`, ready=0 without; ready=1 the next cycle in both builds.
- Hold `rdy`=0 with a ready head → `commit` stays 0 and state holds; raise `rdy` → exactly one commit.
